apb_master: RTL



---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_master_if.sv | 39 +++
 rtl/apb_timeout_cnt.sv | 22 ++
 rtl/apb_master.sv | 78 +++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and defaults for the APB requester and its benches
// Contents: default bus widths, the requester FSM state enum, request/response structs.
package apb_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_master_state_e;
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;
endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command/response port plus APB bus of the single-outstanding requester
// Signals: req_valid/req_ready/req_write/req_addr/req_wdata command handshake;
//          rsp_valid/rsp_rdata/rsp_slverr/rsp_timeout completion pulse;
//          psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr APB bus.
// Modports: master (the requester side), slave (command source + completer side).
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: saturating ACCESS-cycle counter flagging when the wait budget is spent
// Ports: pclk/presetn clock and async active-low reset; i_clr zeroes the count;
//        i_en advances it until it reaches TIMEOUT-1; o_expired is high at that value.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] r_count;
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_count <= '0;
        else if (i_clr) r_count <= '0;
        else if (i_en && !o_expired) r_count <= r_count + 1'b1;
    end
    assign o_expired = r_count == LAST;
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester running SETUP -> ACCESS with a bounded wait
// Ports: pclk/presetn clock and async active-low reset;
//        bus (apb_master_if.master) carries the command port, the one-cycle
//        response pulse and the APB bus toward the completer.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_master_if.master  bus
);
    apb_master_state_e r_state, w_next;
    logic              r_psel, r_penable, r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid, r_rsp_slverr, r_rsp_timeout;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_accept, w_done, w_expired;
    apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .pclk     (pclk),
        .presetn  (presetn),
        .i_clr    (r_state == SETUP),
        .i_en     (r_state == ACCESS),
        .o_expired(w_expired)
    );
    // pready beats an expiring counter in the same cycle
    always_comb begin
        w_accept = r_state == IDLE && bus.req_valid;
        w_done   = r_state == ACCESS && (bus.pready || w_expired);
        w_next   = r_state == IDLE  ? (bus.req_valid ? SETUP : IDLE) :
                   r_state == SETUP ? ACCESS :
                   w_done           ? IDLE : ACCESS;
    end
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_psel      <= w_next != IDLE;
            r_penable   <= w_next == ACCESS;
            r_rsp_valid <= w_done;
            if (w_accept) begin
                r_pwrite <= bus.req_write;
                r_paddr  <= bus.req_addr;
                r_pwdata <= bus.req_wdata;
            end
            // prdata is only trusted on a clean read, so completer X never leaks out
            if (w_done) begin
                r_rsp_rdata   <= (bus.pready && !r_pwrite && !bus.pslverr) ? bus.prdata : '0;
                r_rsp_slverr  <= !bus.pready || bus.pslverr;
                r_rsp_timeout <= !bus.pready;
            end
        end
    end
    assign bus.req_ready   = r_state == IDLE;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_slverr  = r_rsp_slverr;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule
